// File: rtl/mem_read_sched_if.sv
// ----------------------------------------------------------------------------
// mem_read_sched_if
//
// Bundles the requester-side and memory-side signals of the shared memory
// read scheduler.
//
//   Req       requester -> sched   per-requester level request
//   ReqAddr   requester -> sched   burst base address, requester i at [i*AW +: AW]
//   Gnt       sched -> requester   one-hot grant, held for the whole burst
//   Done      sched -> requester   one-hot, one-cycle completion pulse
//   DataBuff  sched -> requester   captured line, word k at [k*DW +: DW]
//   Busy      sched -> requester   high whenever the scheduler is not idle
//   Addr      sched -> memory      read address
//   RD        sched -> memory      read strobe
//   DataOut   memory -> sched      read data, valid the cycle after RD
//
// Modports:
//   master  the scheduler itself
//   slave   the surrounding requesters and memory
// ----------------------------------------------------------------------------
interface mem_read_sched_if #(
    parameter int NREQ  = 4,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int BURST = 16
);
    logic [NREQ-1:0]     Req;
    logic [NREQ*AW-1:0]  ReqAddr;
    logic [NREQ-1:0]     Gnt;
    logic [AW-1:0]       Addr;
    logic                RD;
    logic [DW-1:0]       DataOut;
    logic [DW*BURST-1:0] DataBuff;
    logic [NREQ-1:0]     Done;
    logic                Busy;

    modport master (
        input  Req, ReqAddr, DataOut,
        output Gnt, Addr, RD, DataBuff, Done, Busy
    );

    modport slave (
        output Req, ReqAddr, DataOut,
        input  Gnt, Addr, RD, DataBuff, Done, Busy
    );
endinterface

// File: rtl/mem_read_sched.sv
// ----------------------------------------------------------------------------
// mem_read_sched
//
// Round-robin scheduler sharing one memory read port among NREQ requesters.
// Each winner gets a BURST-word read starting at its ReqAddr; returned words
// are collected into DataBuff and a one-cycle Done pulse tells the winner its
// line is ready.
//
// Ports:
//   Clk   clock, all state updates on the rising edge
//   Rst   asynchronous active-low reset
//   bus   mem_read_sched_if.master (Req/ReqAddr/Gnt/Done/DataBuff/Busy on the
//         requester side, Addr/RD/DataOut on the memory side)
//
// Per transaction (win cycle t): ISSUE t+1..t+16, DRAIN t+17, DONE t+18,
// back in IDLE at t+19.
// ----------------------------------------------------------------------------
module mem_read_sched #(
    parameter int NREQ  = 4,
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int BURST = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    mem_read_sched_if.master  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One extra bit so k can reach BURST; the DRAIN capture then uses k-1.
    localparam int KW = $clog2(BURST) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [KW-1:0]   k_reg;
    logic [AW-1:0]   addr_reg;
    logic            rd_reg;
    logic            rd_d_reg;
    logic            busy_reg;
    logic [NREQ-1:0] gnt_reg;
    logic [NREQ-1:0] done_reg;

    // ------------------------------------------------------------------
    // Round-robin search: scan from ptr upward with wrap, first hit wins.
    // ------------------------------------------------------------------
    logic            hit_next;
    logic [IW-1:0]   win_next;
    logic [IW-1:0]   ptr_next;
    int              idx_c;

    always_comb begin
        hit_next = 1'b0;
        win_next = '0;
        idx_c    = 0;
        for (int j = 0; j < NREQ; j++) begin
            idx_c = int'(ptr_reg) + j;
            if (idx_c >= NREQ) begin
                idx_c = idx_c - NREQ;
            end
            if (!hit_next && bus.Req[idx_c]) begin
                hit_next = 1'b1;
                win_next = IW'(idx_c);
            end
        end
    end

    assign ptr_next = (win_next == IW'(NREQ - 1)) ? '0 : win_next + IW'(1);

    // ------------------------------------------------------------------
    // Control FSM; every output is registered.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            k_reg     <= '0;
            addr_reg  <= '0;
            rd_reg    <= 1'b0;
            rd_d_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            gnt_reg   <= '0;
            done_reg  <= '0;
        end else begin
            done_reg <= '0;
            rd_d_reg <= rd_reg;
            case (state_reg)
                IDLE: begin
                    if (hit_next) begin
                        // ReqAddr is sampled only here, in the win cycle.
                        addr_reg  <= bus.ReqAddr[int'(win_next)*AW +: AW];
                        gnt_reg   <= NREQ'(1) << win_next;
                        ptr_reg   <= ptr_next;
                        k_reg     <= '0;
                        rd_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    k_reg <= k_reg + KW'(1);
                    if (k_reg == KW'(BURST - 1)) begin
                        // Addr keeps the last issued address outside ISSUE.
                        rd_reg    <= 1'b0;
                        state_reg <= DRAIN;
                    end else begin
                        addr_reg <= addr_reg + AW'(1);
                    end
                end
                DRAIN: begin
                    // The grant is one-hot on the winner, so it doubles as
                    // the Done pattern.
                    done_reg  <= gnt_reg;
                    state_reg <= DONE;
                end
                DONE: begin
                    gnt_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line capture. Data for the address issued in cycle c arrives in c+1,
    // when k has already advanced, so the target slot is k-1.
    // ------------------------------------------------------------------
    logic [KW-1:0] cap_slot;
    assign cap_slot = k_reg - KW'(1);

    for (genvar gi = 0; gi < BURST; gi++) begin : g_word
        logic [DW-1:0] word_reg;

        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                word_reg <= '0;
            end else if (rd_d_reg && (cap_slot == KW'(gi))) begin
                word_reg <= bus.DataOut;
            end
        end

        assign bus.DataBuff[gi*DW +: DW] = word_reg;
    end

    assign bus.Gnt  = gnt_reg;
    assign bus.Done = done_reg;
    assign bus.Addr = addr_reg;
    assign bus.RD   = rd_reg;
    assign bus.Busy = busy_reg;

endmodule

// File: tb/tb_mem_read_sched.sv
// ----------------------------------------------------------------------------
// tb_mem_read_sched
//
// Self-checking bench for mem_read_sched. A small memory responder returns
// (Addr + 15) ^ salt one cycle after each RD; a negedge monitor records grant
// rises, Done pulses (with a DataBuff snapshot), issued addresses and idle
// cycles. Each test task computes its expectations from the scheduling rules
// (round-robin pick, 19-cycle transaction timeline, line = memory contents
// at base..base+15) and compares inline.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_read_sched;
    localparam int NREQ  = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int BURST = 16;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    mem_read_sched_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST(BURST)) bus ();

    mem_read_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST(BURST)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit auto_drop = 1'b0;
    logic [15:0] salt = 16'h0000;

    // ------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------
    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return (a + 16'd15) ^ salt;
    endfunction

    always @(posedge Clk) begin
        if (bus.RD) bus.DataOut <= mem_f(bus.Addr);
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    typedef struct { int c; logic [3:0] v; } ev_t;
    typedef struct { int c; logic [3:0] v; logic [255:0] line; } done_t;

    ev_t         gnt_q[$];
    done_t       done_q[$];
    logic [15:0] addr_q[$];
    int          busy_low_q[$];
    logic [3:0]  prev_gnt  = '0;
    logic [3:0]  last_done = '0;
    ev_t         mon_e;
    done_t       mon_d;

    always @(negedge Clk) begin
        if (bus.Gnt != 4'b0 && prev_gnt == 4'b0) begin
            mon_e.c = cyc;
            mon_e.v = bus.Gnt;
            gnt_q.push_back(mon_e);
        end
        prev_gnt = bus.Gnt;
        if (bus.Done != 4'b0) begin
            mon_d.c    = cyc;
            mon_d.v    = bus.Done;
            mon_d.line = bus.DataBuff;
            done_q.push_back(mon_d);
        end
        last_done = bus.Done;
        if (bus.RD) addr_q.push_back(bus.Addr);
        if (!bus.Busy) busy_low_q.push_back(cyc);
    end

    // ------------------------------------------------------------------
    // Reference helpers (spec-level)
    // ------------------------------------------------------------------
    function automatic int rr_pick(input logic [3:0] p, input int from);
        for (int j = 0; j < NREQ; j++) begin
            if (p[(from + j) % NREQ]) return (from + j) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [255:0] exp_line(input logic [15:0] base);
        logic [255:0] l;
        l = '0;
        for (int k = 0; k < BURST; k++) l[k*16 +: 16] = mem_f(base + 16'(k));
        return l;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus plumbing
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge Clk);
        #1;
        if (auto_drop) bus.Req = bus.Req & ~last_done;
    endtask

    task automatic clear_mon();
        gnt_q.delete();
        done_q.delete();
        addr_q.delete();
        busy_low_q.delete();
    endtask

    // Leaves Rst asserted; caller sets up Req/ReqAddr and releases.
    task automatic do_reset();
        auto_drop   = 1'b0;
        salt        = 16'h0000;
        bus.Req     = '0;
        bus.ReqAddr = '0;
        step();
        Rst = 1'b0;
        step();
        step();
        clear_mon();
    endtask

    task automatic wait_done(input int cnt, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_q.size() >= cnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        bus.Req = 4'b1111;
        step();
        checks++;
        if ({bus.Gnt, bus.Done, bus.RD, bus.Busy, bus.Addr} !== 26'b0 || bus.DataBuff !== 256'b0) begin
            errors++;
            $display("FAIL reset_outputs got Gnt=%b Done=%b RD=%b Busy=%b Addr=%h buffnz=%0d exp all zero",
                     bus.Gnt, bus.Done, bus.RD, bus.Busy, bus.Addr, bus.DataBuff != 256'b0);
        end
        checks++;
        if (gnt_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_grant got grants=%0d exp 0", gnt_q.size());
        end
        bus.Req = '0;
        Rst = 1'b1;
        repeat (5) step();
        checks++;
        if (bus.Busy !== 1'b0 || gnt_q.size() != 0) begin
            errors++;
            $display("FAIL idle_no_req got Busy=%b grants=%0d exp Busy=0 grants=0", bus.Busy, gnt_q.size());
        end
    endtask

    task automatic test_single();
        int n;
        bit ok;
        int bad;
        do_reset();
        bus.Req = 4'b0001;
        bus.ReqAddr[0*16 +: 16] = 16'h0080;
        Rst = 1'b1;
        n = cyc;
        wait_done(1, 40, ok);
        bus.Req = '0;
        repeat (3) step();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_timeout got done=%0d exp 1", done_q.size());
        end
        checks++;
        if (gnt_q.size() != 1 || gnt_q[0].v !== 4'b0001 || gnt_q[0].c != n + 1) begin
            errors++;
            $display("FAIL single_grant got n=%0d v=%b c=%0d exp v=0001 c=%0d", gnt_q.size(),
                     gnt_q.size() > 0 ? gnt_q[0].v : 4'bx, gnt_q.size() > 0 ? gnt_q[0].c : -1, n + 1);
        end
        bad = 0;
        for (int k = 0; k < BURST; k++) begin
            if (k >= addr_q.size() || addr_q[k] !== 16'h0080 + 16'(k)) bad++;
        end
        checks++;
        if (bad != 0 || addr_q.size() != BURST) begin
            errors++;
            $display("FAIL single_addr got rd_cycles=%0d bad=%0d exp 16 cycles 0080..008F", addr_q.size(), bad);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0].v !== 4'b0001 || done_q[0].c != n + 18) begin
            errors++;
            $display("FAIL single_done got n=%0d c=%0d exp one pulse 0001 at %0d", done_q.size(),
                     done_q.size() > 0 ? done_q[0].c : -1, n + 18);
        end
        checks++;
        if (done_q.size() < 1 || done_q[0].line !== exp_line(16'h0080)) begin
            errors++;
            $display("FAIL single_line got %h exp %h", done_q.size() > 0 ? done_q[0].line : 256'bx, exp_line(16'h0080));
        end
        checks++;
        if (bus.DataBuff !== exp_line(16'h0080) || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL single_hold got %h busy=%b exp %h busy=0", bus.DataBuff, bus.Busy, exp_line(16'h0080));
        end
    endtask

    task automatic test_two();
        int n;
        bit ok;
        do_reset();
        bus.Req = 4'b0011;
        bus.ReqAddr[0*16 +: 16] = 16'h1000;
        bus.ReqAddr[1*16 +: 16] = 16'h2000;
        Rst = 1'b1;
        n = cyc;
        wait_done(2, 60, ok);
        // ptr should now point at requester 2
        bus.Req = 4'b1111;
        bus.ReqAddr[2*16 +: 16] = 16'h3000;
        bus.ReqAddr[3*16 +: 16] = 16'h4000;
        repeat (3) step();
        bus.Req = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL two_timeout got done=%0d exp 2", done_q.size());
        end
        checks++;
        if (gnt_q.size() < 2 || gnt_q[0].v !== 4'b0001 || gnt_q[0].c != n + 1 ||
            gnt_q[1].v !== 4'b0010 || gnt_q[1].c != n + 20) begin
            errors++;
            $display("FAIL two_grants got n=%0d exp 0001@%0d 0010@%0d", gnt_q.size(), n + 1, n + 20);
        end
        checks++;
        if (done_q.size() < 2 || done_q[0].v !== 4'b0001 || done_q[1].v !== 4'b0010 ||
            done_q[1].line !== exp_line(16'h2000)) begin
            errors++;
            $display("FAIL two_done got n=%0d exp 0001 then 0010 with line of 2000", done_q.size());
        end
        checks++;
        if (gnt_q.size() < 3 || gnt_q[2].v !== 4'b0100) begin
            errors++;
            $display("FAIL two_ptr got %b exp 0100", gnt_q.size() > 2 ? gnt_q[2].v : 4'bx);
        end
    endtask

    task automatic test_full_contention();
        bit ok;
        int bad;
        int lows;
        do_reset();
        bus.Req = 4'b1111;
        for (int i = 0; i < NREQ; i++) bus.ReqAddr[i*16 +: 16] = 16'h0100 * 16'(i + 1);
        Rst = 1'b1;
        wait_done(8, 200, ok);
        bus.Req = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_timeout got done=%0d exp 8", done_q.size());
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (i >= gnt_q.size() || gnt_q[i].v !== 4'(1 << (i % 4))) bad++;
            else if (i > 0 && gnt_q[i].c - gnt_q[i-1].c != 19) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_order got bad=%0d of 8 exp 0,1,2,3,0,1,2,3 every 19 cycles", bad);
        end
        lows = 0;
        if (ok && gnt_q.size() > 0) begin
            foreach (busy_low_q[i]) begin
                if (busy_low_q[i] > gnt_q[0].c && busy_low_q[i] < done_q[7].c) lows++;
            end
        end
        checks++;
        if (lows != 7) begin
            errors++;
            $display("FAIL full_busy_gaps got %0d exp 7", lows);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int bad;
        logic [255:0] l;
        do_reset();
        bus.Req = 4'b0100;
        bus.ReqAddr[2*16 +: 16] = 16'hFFF8;
        Rst = 1'b1;
        wait_done(1, 40, ok);
        bus.Req = '0;
        step();
        bad = 0;
        for (int k = 0; k < BURST; k++) begin
            if (k >= addr_q.size() || addr_q[k] !== 16'hFFF8 + 16'(k)) bad++;
        end
        checks++;
        if (!ok || bad != 0) begin
            errors++;
            $display("FAIL wrap_addr got ok=%0d bad=%0d exp FFF8..FFFF,0000..0007", ok, bad);
        end
        l = bus.DataBuff;
        checks++;
        if (l[8*16 +: 16] !== 16'h000F) begin
            errors++;
            $display("FAIL wrap_slot8 got %h exp 000f", l[8*16 +: 16]);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0].v !== 4'b0100 || l !== exp_line(16'hFFF8)) begin
            errors++;
            $display("FAIL wrap_done got n=%0d line=%h exp 0100 with %h", done_q.size(), l, exp_line(16'hFFF8));
        end
    endtask

    task automatic test_abort();
        int n;
        do_reset();
        bus.Req = 4'b0001;
        bus.ReqAddr[0*16 +: 16] = 16'h1000;
        bus.ReqAddr[1*16 +: 16] = 16'h5000;
        Rst = 1'b1;
        n = cyc;
        repeat (6) step();
        checks++;
        if (bus.RD !== 1'b1 || bus.Addr !== 16'h1005) begin
            errors++;
            $display("FAIL abort_k5 got RD=%b Addr=%h exp RD=1 Addr=1005", bus.RD, bus.Addr);
        end
        Rst = 1'b0;
        #1;
        checks++;
        if ({bus.Gnt, bus.Done, bus.RD, bus.Busy, bus.Addr} !== 26'b0 || bus.DataBuff !== 256'b0) begin
            errors++;
            $display("FAIL abort_outputs got Gnt=%b RD=%b Busy=%b Addr=%h exp all zero",
                     bus.Gnt, bus.RD, bus.Busy, bus.Addr);
        end
        repeat (20) step();
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d exp 0", done_q.size());
        end
        bus.Req = 4'b0011;
        clear_mon();
        Rst = 1'b1;
        n = cyc;
        repeat (4) step();
        bus.Req = '0;
        checks++;
        if (gnt_q.size() != 1 || gnt_q[0].v !== 4'b0001 || gnt_q[0].c != n + 1) begin
            errors++;
            $display("FAIL abort_regrant got n=%0d v=%b exp 0001 at %0d", gnt_q.size(),
                     gnt_q.size() > 0 ? gnt_q[0].v : 4'bx, n + 1);
        end
        repeat (20) step();
    endtask

    task automatic test_drop();
        int n;
        do_reset();
        bus.Req = 4'b0001;
        bus.ReqAddr[0*16 +: 16] = 16'h2222;
        Rst = 1'b1;
        n = cyc;
        repeat (4) step();
        bus.Req = '0;
        repeat (18) step();
        checks++;
        if (done_q.size() != 1 || done_q[0].v !== 4'b0001 || done_q[0].c != n + 18 || gnt_q.size() != 1) begin
            errors++;
            $display("FAIL drop_done got dones=%0d c=%0d grants=%0d exp one 0001 at %0d", done_q.size(),
                     done_q.size() > 0 ? done_q[0].c : -1, gnt_q.size(), n + 18);
        end
        checks++;
        if (addr_q.size() != BURST || bus.DataBuff !== exp_line(16'h2222)) begin
            errors++;
            $display("FAIL drop_line got rd=%0d line=%h exp 16 and %h", addr_q.size(), bus.DataBuff, exp_line(16'h2222));
        end
    endtask

    task automatic test_random();
        int mdl_ptr;
        logic [3:0] pat;
        logic [3:0] pend;
        logic [15:0] base [NREQ];
        int w;
        int nexp;
        int bad;
        do_reset();
        Rst = 1'b1;
        step();
        mdl_ptr = 0;
        for (int r = 0; r < 6; r++) begin
            pat  = 4'($urandom_range(1, 15));
            salt = 16'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                base[i] = 16'($urandom);
                bus.ReqAddr[i*16 +: 16] = base[i];
            end
            clear_mon();
            auto_drop = 1'b1;
            bus.Req = pat;
            for (int i = 0; i < 100 && bus.Req != 4'b0; i++) step();
            auto_drop = 1'b0;
            nexp = $countones(pat);
            checks++;
            if (bus.Req != 4'b0 || done_q.size() != nexp || gnt_q.size() != nexp) begin
                errors++;
                $display("FAIL rand_count round=%0d pat=%b got grants=%0d dones=%0d exp %0d",
                         r, pat, gnt_q.size(), done_q.size(), nexp);
                bus.Req = '0;
                continue;
            end
            pend = pat;
            bad  = 0;
            for (int i = 0; i < nexp; i++) begin
                w = rr_pick(pend, mdl_ptr);
                pend[w] = 1'b0;
                mdl_ptr = (w + 1) % NREQ;
                if (gnt_q[i].v !== 4'(1 << w) || done_q[i].v !== 4'(1 << w)) bad++;
                if (done_q[i].c != gnt_q[i].c + 17) bad++;
                if (done_q[i].line !== exp_line(base[w])) bad++;
                for (int k = 0; k < BURST; k++) begin
                    if (addr_q[i*BURST + k] !== base[w] + 16'(k)) bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_txn round=%0d pat=%b got %0d discrepancies exp 0", r, pat, bad);
            end
        end
    endtask

    initial begin
        bus.Req     = '0;
        bus.ReqAddr = '0;
        test_reset();
        test_single();
        test_two();
        test_full_contention();
        test_wrap();
        test_abort();
        test_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
